// File: rtl/voice_mixer_pkg.sv
// Shared audio definitions used by the mixer, envelope and oscillator blocks.
//   SAMPLE_W / VOLUME_W : widths of one oscillator sample and one volume value
//   mix_state_t         : 2-bit state encoding of the voice mixer FSM
//   voice_product()     : signed sample times unsigned volume, 17-bit signed
package voice_mixer_pkg;

    localparam int SAMPLE_W = 8;
    localparam int VOLUME_W = 8;
    localparam int PROD_W   = SAMPLE_W + VOLUME_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } mix_state_t;

    // Volume is zero-extended so it multiplies as a non-negative value;
    // the full product (-32640..32385) always fits 17 signed bits.
    function automatic logic signed [PROD_W-1:0] voice_product(
        input logic signed [SAMPLE_W-1:0] sample,
        input logic        [VOLUME_W-1:0] volume
    );
        logic signed [PROD_W-1:0] sample_ext;
        logic signed [PROD_W-1:0] volume_ext;
        sample_ext = PROD_W'(sample);
        volume_ext = {1'b0, volume};
        return sample_ext * volume_ext;
    endfunction

endpackage

// File: rtl/mix_saturate.sv
// Combinational clamp of the scaled mix to the 16-bit output range.
//   in_value  : signed IN_W-bit scaled mix
//   out_value : signed 16-bit result, clamped to [-32768, 32767]
module mix_saturate #(
    parameter int IN_W = 28
) (
    input  logic signed [IN_W-1:0] in_value,
    output logic signed [15:0]     out_value
);

    logic [IN_W-16:0] top_bits;

    // The value fits 16 bits exactly when every bit from 15 upward equals
    // the sign bit; otherwise clamp toward the side the sign indicates.
    always_comb begin
        top_bits  = in_value[IN_W-1:15];
        out_value = in_value[15:0];
        if (!((top_bits == '0) || (top_bits == '1))) begin
            out_value = in_value[IN_W-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Multi-voice audio mixer. On each sample_tick the per-voice inputs are
// snapshotted, multiplied-and-accumulated one voice per clock, scaled by the
// master volume, saturated and presented on out_sample with an out_valid pulse.
//
// Handshake: sample_tick is a fire-and-forget request accepted only in IDLE;
// a tick seen in any other state is dropped and reported on overrun for one
// cycle. out_valid is a one-cycle strobe with no back-pressure; out_sample
// holds its value until the next strobe.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   sample_tick     : starts a mix
//   voice_sample    : signed 8-bit sample per voice, voice i at [8i+7:8i]
//   voice_volume    : unsigned 8-bit volume per voice, same packing
//   voice_enable    : per-voice enable
//   master_volume   : unsigned master gain
//   out_sample      : signed 16-bit mixed sample
//   out_valid       : one-cycle pulse when out_sample updates
//   busy            : FSM not in IDLE
//   overrun         : one-cycle pulse when a tick is dropped
//   state_dbg       : current FSM state encoding
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 17 + $clog2(NUM_VOICES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_tick,
    input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
    input  logic [VOLUME_W*NUM_VOICES-1:0] voice_volume,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    input  logic [7:0]                     master_volume,
    output logic signed [15:0]             out_sample,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [1:0]                     state_dbg
);

    localparam int SCALED_W = ACC_W + 9;
    localparam int IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    mix_state_t                      state;
    logic [IDX_W-1:0]                index;
    logic signed [ACC_W-1:0]         acc;
    logic signed [SCALED_W-1:0]      scaled;

    // Snapshots shift right by one voice per MAC cycle so the voice being
    // accumulated is always in the lowest slot.
    logic [SAMPLE_W*NUM_VOICES-1:0]  snap_sample;
    logic [VOLUME_W*NUM_VOICES-1:0]  snap_volume;
    logic [NUM_VOICES-1:0]           snap_enable;
    logic [7:0]                      snap_master;

    logic signed [PROD_W-1:0]        cur_product;
    logic signed [ACC_W-1:0]         cur_product_ext;
    logic signed [SCALED_W-1:0]      acc_wide;
    logic signed [SCALED_W-1:0]      master_wide;
    logic signed [SCALED_W-1:0]      scale_prod;
    logic signed [15:0]              sat_value;

    always_comb begin
        cur_product = '0;
        if (snap_enable[0]) begin
            cur_product = voice_product(snap_sample[SAMPLE_W-1:0],
                                        snap_volume[VOLUME_W-1:0]);
        end
        cur_product_ext = ACC_W'(cur_product);
        acc_wide        = SCALED_W'(acc);
        master_wide     = {{(SCALED_W-8){1'b0}}, snap_master};
        // ACC_W + 9 bits hold any accumulator times an 8-bit unsigned gain.
        scale_prod      = acc_wide * master_wide;
    end

    mix_saturate #(
        .IN_W(SCALED_W)
    ) u_saturate (
        .in_value  (scaled),
        .out_value (sat_value)
    );

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            index       <= '0;
            acc         <= '0;
            scaled      <= '0;
            snap_sample <= '0;
            snap_volume <= '0;
            snap_enable <= '0;
            snap_master <= '0;
            out_sample  <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;

            // Any tick outside IDLE, including one on the DONE edge, is lost.
            if (sample_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        snap_sample <= voice_sample;
                        snap_volume <= voice_volume;
                        snap_enable <= voice_enable;
                        snap_master <= master_volume;
                        acc         <= '0;
                        index       <= '0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc         <= acc + cur_product_ext;
                    snap_sample <= snap_sample >> SAMPLE_W;
                    snap_volume <= snap_volume >> VOLUME_W;
                    snap_enable <= snap_enable >> 1;
                    if (index == LAST_IDX) begin
                        index <= '0;
                        state <= ST_SCALE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                ST_SCALE: begin
                    // Arithmetic shift floors toward negative infinity.
                    scaled <= scale_prod >>> 8;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    out_sample <= sat_value;
                    out_valid  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

    typedef struct {
        string             name;
        logic [31:0]       smp;
        logic [31:0]       vol;
        logic [3:0]        en;
        logic [7:0]        mst;
        logic signed [15:0] exp_out;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               sample_tick;
    logic [31:0]        voice_sample;
    logic [31:0]        voice_volume;
    logic [3:0]         voice_enable;
    logic [7:0]         master_volume;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               busy;
    logic               overrun;
    logic [1:0]         state_dbg;

    int          n_cmp;
    int          n_bad;
    int          valid_count;
    int          ovr_count;
    logic [15:0] exp_q[$];
    vec_t        vecs[10];

    voice_mixer #(
        .NUM_VOICES(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .voice_sample  (voice_sample),
        .voice_volume  (voice_volume),
        .voice_enable  (voice_enable),
        .master_volume (master_volume),
        .out_sample    (out_sample),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got out_valid with value %0d, expected none",
                         out_sample);
            end else begin
                check("out_sample", out_sample, $signed(exp_q.pop_front()));
            end
        end
        if (rst_n && overrun) ovr_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic apply_inputs(input vec_t v);
        voice_sample  = v.smp;
        voice_volume  = v.vol;
        voice_enable  = v.en;
        master_volume = v.mst;
    endtask

    // Issues one tick and checks latency, busy, pulse width and hold.
    task automatic run_mix(input vec_t v);
        int cyc;
        bit busy_ok;
        apply_inputs(v);
        @(negedge clk);
        sample_tick = 1'b1;
        exp_q.push_back(v.exp_out);
        @(negedge clk);
        sample_tick = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({v.name, "_latency"}, cyc, 6);
        check({v.name, "_busy"}, 32'(busy_ok), 1);
        @(negedge clk);
        check({v.name, "_valid_pulse"}, 32'(out_valid), 0);
        repeat (3) @(negedge clk);
        check({v.name, "_hold"}, out_sample, v.exp_out);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        int o0;
        n_cmp = 0;
        n_bad = 0;
        valid_count = 0;
        ovr_count = 0;
        sample_tick = 1'b0;
        voice_sample = '0;
        voice_volume = '0;
        voice_enable = '0;
        master_volume = '0;

        vecs[0] = '{"single",   32'h00000064, 32'h000000FF, 4'b0001, 8'hFF,  16'sd25400};
        vecs[1] = '{"sat_pos",  32'h7F7F7F7F, 32'hFFFFFFFF, 4'b1111, 8'hFF,  16'sd32767};
        vecs[2] = '{"sat_neg",  32'h80808080, 32'hFFFFFFFF, 4'b1111, 8'hFF, -16'sd32768};
        vecs[3] = '{"floor_m1", 32'h7F7F7FFF, 32'hFFFFFF01, 4'b0001, 8'h01, -16'sd1};
        vecs[4] = '{"floor_p1", 32'h7F7F7F01, 32'hFFFFFF01, 4'b0001, 8'h01,  16'sd0};
        vecs[5] = '{"mixed",    32'h800AE232, 32'h64FFC880, 4'b1011, 8'h80, -16'sd6200};
        vecs[6] = '{"ramp",     32'h503C2814, 32'h64646464, 4'b1111, 8'hC8,  16'sd15625};
        vecs[7] = '{"floor_m3", 32'h000000FD, 32'h00000001, 4'b0001, 8'h64, -16'sd2};
        vecs[8] = '{"master0",  32'h7F7F7F7F, 32'hFFFFFFFF, 4'b1111, 8'h00,  16'sd0};
        vecs[9] = '{"all_off",  32'h7F7F7F7F, 32'hFFFFFFFF, 4'b0000, 8'hFF,  16'sd0};

        // Reset takes effect with no clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_sample", out_sample, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_state", 32'(state_dbg), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            run_mix(vecs[i]);
        end

        // Overrun two cycles after an accepted tick; inputs change mid-MAC.
        v0 = valid_count;
        o0 = ovr_count;
        apply_inputs(vecs[0]);
        @(negedge clk);
        sample_tick = 1'b1;
        exp_q.push_back(vecs[0].exp_out);
        @(negedge clk);                       // after E0
        sample_tick = 1'b0;
        apply_inputs(vecs[1]);
        @(negedge clk);                       // after E1
        sample_tick = 1'b1;
        @(negedge clk);                       // after E2
        sample_tick = 1'b0;
        check("overrun_pulse", 32'(overrun), 1);
        @(negedge clk);
        check("overrun_width", 32'(overrun), 0);
        repeat (15) @(negedge clk);
        check("overrun_count", ovr_count - o0, 1);
        check("overrun_valid_count", valid_count - v0, 1);

        // Tick landing on the DONE edge is dropped.
        v0 = valid_count;
        o0 = ovr_count;
        apply_inputs(vecs[6]);
        @(negedge clk);
        sample_tick = 1'b1;
        exp_q.push_back(vecs[6].exp_out);
        @(negedge clk);                       // after E0
        sample_tick = 1'b0;
        repeat (5) @(negedge clk);            // after E5
        sample_tick = 1'b1;
        @(negedge clk);                       // after E6
        sample_tick = 1'b0;
        check("done_tick_valid", 32'(out_valid), 1);
        check("done_tick_overrun", 32'(overrun), 1);
        repeat (12) @(negedge clk);
        check("done_tick_ovr_count", ovr_count - o0, 1);
        check("done_tick_valid_count", valid_count - v0, 1);

        // Reset in the middle of MAC abandons the mix.
        apply_inputs(vecs[1]);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);                       // after E0
        sample_tick = 1'b0;
        @(negedge clk);                       // after E1
        rst_n = 1'b0;
        #1;
        check("midrst_out_sample", out_sample, 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_state", 32'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_count;
        repeat (12) @(negedge clk);
        check("midrst_no_valid", valid_count - v0, 0);
        run_mix(vecs[0]);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
